result_drain_serializer: RTL and testbench

- Downstream of the 32-lane vector multiplier: takes each 32 x 24-bit result vector as a single 768-bit word.
- Holds up to two vectors in a ping-pong buffer.
- Emits each vector as a valid/ready stream of narrow beats, with vector/beat indices, to a host or DMA port.
- Counts NUM_VECTORS results per run and flags done and overflow.

---
 rtl/result_drain_serializer_pkg.sv | 19 +
 rtl/result_drain_serializer_if.sv | 27 ++
 rtl/result_drain_serializer_pingpong_buf.sv | 61 ++++++
 rtl/result_drain_serializer.sv | 99 +++++++++
 tb/tb_result_drain_serializer.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/result_drain_serializer_pkg.sv
// Sizing and state encoding shared by the result drain serializer, its buffer and its bus.
package result_drain_serializer_pkg;
  localparam int PARTIAL_SUM_BW = 24;
  localparam int MATRIX_SIZE    = 32;
  localparam int BEAT_LANES     = 4;
  localparam int NUM_VECTORS    = 64;
  localparam int BEATS          = MATRIX_SIZE / BEAT_LANES;
  localparam int VEC_W          = PARTIAL_SUM_BW * MATRIX_SIZE;
  localparam int BEAT_W         = PARTIAL_SUM_BW * BEAT_LANES;
  localparam int BEAT_IDX_W     = $clog2(BEATS);
  localparam int VEC_IDX_W      = $clog2(NUM_VECTORS);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;
endpackage

// File: rtl/result_drain_serializer_if.sv
// Producer/consumer bus of the result drain serializer; slave is the serializer's view.
interface result_drain_serializer_if;
  import result_drain_serializer_pkg::*;

  logic                  start;
  logic                  in_valid;
  logic [VEC_W-1:0]      in_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [BEAT_W-1:0]     out_data;
  logic [BEAT_IDX_W-1:0] out_beat_idx;
  logic [VEC_IDX_W-1:0]  out_vec_idx;
  logic                  out_last;
  logic                  busy;
  logic                  done;
  logic                  overflow;

  modport master (
    output start, in_valid, in_data, out_ready,
    input  out_valid, out_data, out_beat_idx, out_vec_idx, out_last, busy, done, overflow
  );

  modport slave (
    input  start, in_valid, in_data, out_ready,
    output out_valid, out_data, out_beat_idx, out_vec_idx, out_last, busy, done, overflow
  );
endinterface

// File: rtl/result_drain_serializer_pingpong_buf.sv
// Two-entry ping-pong store for result vectors; the head entry is read while the other slot fills.
module result_pingpong_buf
  import result_drain_serializer_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [VEC_W-1:0] wdata_i,
  output logic [VEC_W-1:0] head_o,
  output logic             accept_o,
  output logic             empty_o
);
  logic [VEC_W-1:0] mem_q [2];
  logic             wptr_q, wptr_d;
  logic             rptr_q, rptr_d;
  logic [1:0]       occ_q, occ_d;
  logic             full, do_pop;

  assign full     = (occ_q == 2'd2);
  assign empty_o  = (occ_q == 2'd0);
  assign do_pop   = pop_i && !empty_o;
  // A full buffer still takes a vector when the head leaves in the same cycle.
  assign accept_o = push_i && (!full || do_pop);
  assign head_o   = mem_q[rptr_q];

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    occ_d  = occ_q;
    if (flush_i) begin
      wptr_d = 1'b0;
      rptr_d = 1'b0;
      occ_d  = 2'd0;
    end else begin
      if (accept_o) wptr_d = ~wptr_q;
      if (do_pop)   rptr_d = ~rptr_q;
      case ({accept_o, do_pop})
        2'b10:   occ_d = occ_q + 2'd1;
        2'b01:   occ_d = occ_q - 2'd1;
        default: occ_d = occ_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wptr_q   <= 1'b0;
      rptr_q   <= 1'b0;
      occ_q    <= 2'd0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      occ_q  <= occ_d;
      if (accept_o && !flush_i) mem_q[wptr_q] <= wdata_i;
    end
  end
endmodule

// File: rtl/result_drain_serializer.sv
// Buffers 768-bit result vectors and drains them as indexed narrow beats, counting one run.
//   state    | meaning
//   ST_IDLE  | waiting for start, input ignored
//   ST_RUN   | accepting vectors and emitting beats
//   ST_DRAIN | all vectors taken, emitting remaining beats
//   ST_DONE  | run complete, done high until next start
module result_drain_serializer
  import result_drain_serializer_pkg::*;
(
  input logic                      clk,
  input logic                      rst,
  result_drain_serializer_if.slave res_bus
);
  localparam logic [BEAT_IDX_W-1:0] LAST_BEAT = BEAT_IDX_W'(BEATS - 1);
  localparam logic [VEC_IDX_W-1:0]  LAST_VEC  = VEC_IDX_W'(NUM_VECTORS - 1);

  state_e                state_q, state_d;
  logic [BEAT_IDX_W-1:0] beat_q, beat_d;
  logic [VEC_IDX_W-1:0]  vec_q, vec_d;
  logic [VEC_IDX_W-1:0]  acc_q, acc_d;
  logic                  ovf_q, ovf_d;

  logic             active, out_valid, hs, last_hs, push, accept, empty;
  logic [VEC_W-1:0] head;

  assign active    = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign out_valid = active && !empty;
  assign hs        = out_valid && res_bus.out_ready && !res_bus.start;
  assign last_hs   = hs && (beat_q == LAST_BEAT);
  assign push      = (state_q == ST_RUN) && res_bus.in_valid && !res_bus.start;

  result_pingpong_buf u_buf (
    .clk      (clk),
    .rst      (rst),
    .flush_i  (res_bus.start),
    .push_i   (push),
    .pop_i    (last_hs),
    .wdata_i  (res_bus.in_data),
    .head_o   (head),
    .accept_o (accept),
    .empty_o  (empty)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  state_d = ST_IDLE;
      ST_RUN:   if (accept && acc_q == LAST_VEC) state_d = ST_DRAIN;
      ST_DRAIN: if (last_hs && vec_q == LAST_VEC) state_d = ST_DONE;
      ST_DONE:  state_d = ST_DONE;
      default:  state_d = ST_IDLE;
    endcase
    if (res_bus.start) state_d = ST_RUN;
  end

  always_comb begin
    beat_d = beat_q;
    vec_d  = vec_q;
    acc_d  = acc_q;
    ovf_d  = ovf_q;
    if (res_bus.start) begin
      beat_d = '0;
      vec_d  = '0;
      acc_d  = '0;
      ovf_d  = 1'b0;
    end else begin
      if (hs)              beat_d = last_hs ? '0 : beat_q + 1'b1;
      if (last_hs)         vec_d  = vec_q + 1'b1;
      if (accept)          acc_d  = acc_q + 1'b1;
      if (push && !accept) ovf_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      beat_q  <= '0;
      vec_q   <= '0;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      vec_q   <= vec_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
    end
  end

  // Beat select comes from registered pointer and counter, so it holds steady under stall.
  assign res_bus.out_valid    = out_valid;
  assign res_bus.out_data     = head[int'(beat_q)*BEAT_W +: BEAT_W];
  assign res_bus.out_beat_idx = beat_q;
  assign res_bus.out_vec_idx  = vec_q;
  assign res_bus.out_last     = out_valid && (beat_q == LAST_BEAT);
  assign res_bus.busy         = active;
  assign res_bus.done         = (state_q == ST_DONE);
  assign res_bus.overflow     = ovf_q;
endmodule

// File: tb/tb_result_drain_serializer.sv
// Directed bench for the result drain serializer: latency, full run, stall, overflow, restart, reset.
module tb_result_drain_serializer;
  import result_drain_serializer_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  result_drain_serializer_if bus ();

  result_drain_serializer dut (
    .clk     (clk),
    .rst     (rst),
    .res_bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  int                        inj_cyc[$];
  logic [PARTIAL_SUM_BW-1:0] inj_base[$];
  logic [PARTIAL_SUM_BW-1:0] exp_base[$];

  int                beats, errs, ncyc, cnt;
  logic [BEAT_W-1:0] last_d;

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [VEC_W-1:0] mkvec(input logic [PARTIAL_SUM_BW-1:0] base);
    logic [VEC_W-1:0] v;
    v = '0;
    for (int i = 0; i < MATRIX_SIZE; i++)
      v[i*PARTIAL_SUM_BW +: PARTIAL_SUM_BW] = base + PARTIAL_SUM_BW'(i);
    return v;
  endfunction

  function automatic logic [BEAT_W-1:0] mkbeat(input logic [PARTIAL_SUM_BW-1:0] base, input int k);
    logic [BEAT_W-1:0] b;
    b = '0;
    for (int j = 0; j < BEAT_LANES; j++)
      b[j*PARTIAL_SUM_BW +: PARTIAL_SUM_BW] = base + PARTIAL_SUM_BW'(k*BEAT_LANES + j);
    return b;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic send(input logic [PARTIAL_SUM_BW-1:0] base);
    bus.in_valid = 1'b1;
    bus.in_data  = mkvec(base);
    tick();
    bus.in_valid = 1'b0;
  endtask

  // Runs cycles, injecting queued vectors and scoring every handshake against exp_base.
  task automatic stream(input int target, input int budget, output int beats_o,
                        output int errs_o, output int ncyc_o, output logic [BEAT_W-1:0] last_o);
    int vi, k;
    beats_o = 0;
    errs_o  = 0;
    ncyc_o  = 0;
    last_o  = '0;
    for (int c = 0; c < budget && beats_o < target; c++) begin
      bus.in_valid = 1'b0;
      if (inj_cyc.size() > 0 && inj_cyc[0] == c) begin
        bus.in_valid = 1'b1;
        bus.in_data  = mkvec(inj_base[0]);
        void'(inj_cyc.pop_front());
        void'(inj_base.pop_front());
      end
      if (bus.out_valid && bus.out_ready) begin
        vi = beats_o / BEATS;
        k  = beats_o % BEATS;
        if (vi >= exp_base.size()) errs_o++;
        else begin
          if (bus.out_data !== mkbeat(exp_base[vi], k)) errs_o++;
          if (int'(bus.out_beat_idx) != k) errs_o++;
          if (int'(bus.out_vec_idx) != vi) errs_o++;
          if (bus.out_last !== (k == BEATS - 1)) errs_o++;
        end
        last_o = bus.out_data;
        beats_o++;
      end
      tick();
      ncyc_o++;
    end
    bus.in_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    #12;
    check_val("rst_valid", 128'(bus.out_valid), 128'(0));
    check_val("rst_data",  128'(bus.out_data), 128'(0));
    check_val("rst_busy",  128'(bus.busy), 128'(0));
    check_val("rst_done",  128'(bus.done), 128'(0));
    check_val("rst_ovf",   128'(bus.overflow), 128'(0));
    check_val("rst_idx",   128'({bus.out_vec_idx, bus.out_beat_idx, bus.out_last}), 128'(0));
    tick();
    rst = 1'b0;
    tick();

    // 1: single vector, lane i = i
    pulse_start();
    check_val("t1_busy", 128'(bus.busy), 128'(1));
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = mkvec(24'd0);
    check_val("t1_valid_pre", 128'(bus.out_valid), 128'(0));
    tick();
    bus.in_valid = 1'b0;
    check_val("t1_valid_lat", 128'(bus.out_valid), 128'(1));
    check_val("t1_beat0", 128'(bus.out_data), 128'(96'h000003_000002_000001_000000));
    check_val("t1_last0", 128'(bus.out_last), 128'(0));
    exp_base.delete();
    exp_base.push_back(24'd0);
    stream(8, 20, beats, errs, ncyc, last_d);
    check_val("t1_beats", 128'(beats), 128'(8));
    check_val("t1_errs", 128'(errs), 128'(0));
    check_val("t1_cycles", 128'(ncyc), 128'(8));
    check_val("t1_beat7", 128'(last_d), 128'(96'h00001F_00001E_00001D_00001C));
    check_val("t1_empty", 128'(bus.out_valid), 128'(0));

    // 2: full run of NUM_VECTORS spaced BEATS apart
    pulse_start();
    exp_base.delete();
    for (int v = 0; v < NUM_VECTORS; v++) begin
      inj_cyc.push_back(v * BEATS);
      inj_base.push_back(24'hA50000 + 24'(v * 32));
      exp_base.push_back(24'hA50000 + 24'(v * 32));
    end
    stream(NUM_VECTORS * BEATS, 700, beats, errs, ncyc, last_d);
    check_val("t2_beats", 128'(beats), 128'(512));
    check_val("t2_errs", 128'(errs), 128'(0));
    check_val("t2_cycles", 128'(ncyc), 128'(513));
    check_val("t2_done", 128'(bus.done), 128'(1));
    check_val("t2_busy", 128'(bus.busy), 128'(0));
    check_val("t2_ovf", 128'(bus.overflow), 128'(0));
    check_val("t2_valid", 128'(bus.out_valid), 128'(0));
    inj_cyc.delete();
    inj_base.delete();

    // 3: stalled consumer, third vector dropped
    pulse_start();
    check_val("t3_done_clr", 128'(bus.done), 128'(0));
    check_val("t3_busy", 128'(bus.busy), 128'(1));
    bus.out_ready = 1'b0;
    send(24'h100000);
    send(24'h200000);
    check_val("t3_ovf_pre", 128'(bus.overflow), 128'(0));
    send(24'h300000);
    check_val("t3_ovf", 128'(bus.overflow), 128'(1));
    check_val("t3_valid", 128'(bus.out_valid), 128'(1));
    repeat (3) tick();
    check_val("t3_hold", 128'(bus.out_data), 128'(mkbeat(24'h100000, 0)));
    check_val("t3_hold_idx", 128'(bus.out_beat_idx), 128'(0));
    bus.out_ready = 1'b1;
    exp_base.delete();
    exp_base.push_back(24'h100000);
    exp_base.push_back(24'h200000);
    stream(16, 40, beats, errs, ncyc, last_d);
    check_val("t3_beats", 128'(beats), 128'(16));
    check_val("t3_errs", 128'(errs), 128'(0));
    check_val("t3_no_third", 128'(bus.out_valid), 128'(0));

    // 4: push while full, coinciding with head's last-beat handshake
    pulse_start();
    bus.out_ready = 1'b0;
    send(24'h110000);
    send(24'h220000);
    bus.out_ready = 1'b1;
    inj_cyc.push_back(7);
    inj_base.push_back(24'h330000);
    exp_base.delete();
    exp_base.push_back(24'h110000);
    exp_base.push_back(24'h220000);
    exp_base.push_back(24'h330000);
    stream(24, 60, beats, errs, ncyc, last_d);
    check_val("t4_beats", 128'(beats), 128'(24));
    check_val("t4_errs", 128'(errs), 128'(0));
    check_val("t4_cycles", 128'(ncyc), 128'(24));
    check_val("t4_ovf", 128'(bus.overflow), 128'(0));
    inj_cyc.delete();
    inj_base.delete();

    // 5: start mid-run with a simultaneous in_valid
    pulse_start();
    bus.out_ready = 1'b0;
    send(24'h400000);
    send(24'h500000);
    send(24'h600000);
    bus.out_ready = 1'b1;
    repeat (11) tick();
    bus.out_ready = 1'b0;
    check_val("t5_pre_vec", 128'(bus.out_vec_idx), 128'(1));
    check_val("t5_pre_beat", 128'(bus.out_beat_idx), 128'(3));
    check_val("t5_pre_ovf", 128'(bus.overflow), 128'(1));
    bus.start    = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = mkvec(24'h700000);
    tick();
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    check_val("t5_valid", 128'(bus.out_valid), 128'(0));
    check_val("t5_beat", 128'(bus.out_beat_idx), 128'(0));
    check_val("t5_vec", 128'(bus.out_vec_idx), 128'(0));
    check_val("t5_ovf", 128'(bus.overflow), 128'(0));
    check_val("t5_run", 128'({bus.busy, bus.done}), 128'(2'b10));
    bus.out_ready = 1'b1;
    cnt = 0;
    for (int c = 0; c < 20; c++) begin
      if (bus.out_valid) cnt++;
      tick();
    end
    check_val("t5_no_emit", 128'(cnt), 128'(0));

    // 6: asynchronous reset mid-beat, then input without start
    pulse_start();
    bus.out_ready = 1'b1;
    send(24'h800000);
    tick();
    tick();
    check_val("t6_pre_beat", 128'(bus.out_beat_idx), 128'(2));
    #3;
    rst = 1'b1;
    #1;
    check_val("t6_valid", 128'(bus.out_valid), 128'(0));
    check_val("t6_data", 128'(bus.out_data), 128'(0));
    check_val("t6_idx", 128'({bus.out_vec_idx, bus.out_beat_idx, bus.out_last}), 128'(0));
    check_val("t6_flags", 128'({bus.busy, bus.done, bus.overflow}), 128'(0));
    #2;
    rst = 1'b0;
    tick();
    cnt = 0;
    for (int c = 0; c < 20; c++) begin
      bus.in_valid = (c < 3);
      bus.in_data  = mkvec(24'h900000 + 24'(c * 32));
      if (bus.out_valid) cnt++;
      tick();
    end
    bus.in_valid = 1'b0;
    check_val("t6_no_beats", 128'(cnt), 128'(0));
    check_val("t6_no_ovf", 128'(bus.overflow), 128'(0));
    check_val("t6_idle", 128'(bus.busy), 128'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
